// File: rtl/ecc_point_add.sv
`default_nettype none
// ============================================================================
// Module   : ecc_point_add (with its combinational INV_IP modular inverse)
// Purpose  : Sequential affine point add/double over GF(p), y^2 = x^3 + a*x + b
// Revision : 1.0
// ============================================================================

module INV_IP #(
    parameter int IP_WIDTH = 6
) (
    input  logic [IP_WIDTH-1:0] IN_1,
    input  logic [IP_WIDTH-1:0] IN_2,
    output logic [IP_WIDTH-1:0] OUT_INV
);
    localparam int C_W2 = 2 * IP_WIDTH;

    logic [C_W2-1:0] w_mod;
    logic [C_W2-1:0] w_val;

    assign w_mod = {{IP_WIDTH{1'b0}}, IN_1};
    assign w_val = {{IP_WIDTH{1'b0}}, IN_2};

    // Descending scan leaves the smallest candidate, which lies in [1, p-1].
    always_comb begin
        OUT_INV = '0;
        for (int i = (1 << IP_WIDTH) - 1; i >= 1; i--) begin
            if (((C_W2'(i) * w_val) % w_mod) == C_W2'(1)) begin
                OUT_INV = IP_WIDTH'(i);
            end
        end
    end
endmodule

module ecc_point_add #(
    parameter int IP_WIDTH = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [IP_WIDTH-1:0] in_x,
    input  logic [IP_WIDTH-1:0] in_y,
    output logic                out_valid,
    output logic [IP_WIDTH-1:0] out_data
);
    localparam int C_W  = IP_WIDTH;
    localparam int C_W2 = 2 * IP_WIDTH;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_IN1   = 4'd1,
        S_IN2   = 4'd2,
        S_DEN   = 4'd3,
        S_INV   = 4'd4,
        S_SLOPE = 4'd5,
        S_X3    = 4'd6,
        S_Y3    = 4'd7,
        S_OUT_X = 4'd8,
        S_OUT_Y = 4'd9
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [C_W-1:0] r_px, r_py, r_qx, r_qy, r_p, r_a;
    logic [C_W-1:0] r_num, r_den, r_inv, r_s, r_rx, r_ry;

    function automatic logic [C_W-1:0] mod_add(input logic [C_W-1:0] x,
                                               input logic [C_W-1:0] y,
                                               input logic [C_W-1:0] m);
        logic [C_W:0] sum;
        sum = {1'b0, x} + {1'b0, y};
        if (sum >= {1'b0, m}) begin
            sum = sum - {1'b0, m};
        end
        return sum[C_W-1:0];
    endfunction

    function automatic logic [C_W-1:0] mod_sub(input logic [C_W-1:0] x,
                                               input logic [C_W-1:0] y,
                                               input logic [C_W-1:0] m);
        logic [C_W:0] diff;
        if (x >= y) begin
            diff = {1'b0, x} - {1'b0, y};
        end else begin
            diff = {1'b0, x} + {1'b0, m} - {1'b0, y};
        end
        return diff[C_W-1:0];
    endfunction

    function automatic logic [C_W-1:0] mod_mul(input logic [C_W-1:0] x,
                                               input logic [C_W-1:0] y,
                                               input logic [C_W-1:0] m);
        logic [C_W2-1:0] prod;
        logic [C_W2-1:0] rem;
        prod = {{C_W{1'b0}}, x} * {{C_W{1'b0}}, y};
        rem  = prod % {{C_W{1'b0}}, m};
        return rem[C_W-1:0];
    endfunction

    logic           w_doubling;
    logic [C_W-1:0] w_px_sq;
    logic [C_W-1:0] w_num_dbl, w_den_dbl, w_num_add, w_den_add;
    logic [C_W-1:0] w_inv;

    assign w_doubling = (r_px == r_qx) && (r_py == r_qy);
    assign w_px_sq    = mod_mul(r_px, r_px, r_p);
    // 3*Px^2 + a, reduced after every term
    assign w_num_dbl  = mod_add(mod_add(mod_add(w_px_sq, w_px_sq, r_p), w_px_sq, r_p), r_a, r_p);
    assign w_den_dbl  = mod_add(r_py, r_py, r_p);
    assign w_num_add  = mod_sub(r_qy, r_py, r_p);
    assign w_den_add  = mod_sub(r_qx, r_px, r_p);

    INV_IP #(
        .IP_WIDTH(IP_WIDTH)
    ) u_inv (
        .IN_1   (r_p),
        .IN_2   (r_den),
        .OUT_INV(w_inv)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_IN1;
            S_IN1:   w_next = S_IN2;
            S_IN2:   w_next = S_DEN;
            S_DEN:   w_next = S_INV;
            S_INV:   w_next = S_SLOPE;
            S_SLOPE: w_next = S_X3;
            S_X3:    w_next = S_Y3;
            S_Y3:    w_next = S_OUT_X;
            S_OUT_X: w_next = S_OUT_Y;
            S_OUT_Y: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_px      <= '0;
            r_py      <= '0;
            r_qx      <= '0;
            r_qy      <= '0;
            r_p       <= '0;
            r_a       <= '0;
            r_num     <= '0;
            r_den     <= '0;
            r_inv     <= '0;
            r_s       <= '0;
            r_rx      <= '0;
            r_ry      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            out_data  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_px <= in_x;
                        r_py <= in_y;
                    end
                end
                S_IN1: begin
                    r_qx <= in_x;
                    r_qy <= in_y;
                end
                S_IN2: begin
                    r_p <= in_x;
                    r_a <= in_y;
                end
                S_DEN: begin
                    r_num <= w_doubling ? w_num_dbl : w_num_add;
                    r_den <= w_doubling ? w_den_dbl : w_den_add;
                end
                S_INV:   r_inv <= w_inv;
                S_SLOPE: r_s   <= mod_mul(r_num, r_inv, r_p);
                S_X3:    r_rx  <= mod_sub(mod_sub(mod_mul(r_s, r_s, r_p), r_px, r_p), r_qx, r_p);
                S_Y3:    r_ry  <= mod_sub(mod_mul(r_s, mod_sub(r_px, r_rx, r_p), r_p), r_py, r_p);
                S_OUT_X: begin
                    out_valid <= 1'b1;
                    out_data  <= r_rx;
                end
                S_OUT_Y: begin
                    out_valid <= 1'b1;
                    out_data  <= r_ry;
                end
                default: begin
                    out_valid <= 1'b0;
                    out_data  <= '0;
                end
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_ecc_point_add.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_point_add
// Purpose  : Directed and golden-model checks for ecc_point_add
// Revision : 1.0
// ============================================================================

module tb_ecc_point_add;
    localparam int W = 6;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_x;
    logic [W-1:0] in_y;
    logic         out_valid;
    logic [W-1:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    ecc_point_add #(
        .IP_WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_x     (in_x),
        .in_y     (in_y),
        .out_valid(out_valid),
        .out_data (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [W-1:0] px, py, qx, qy, p, a, rx, ry;
        string        name;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int md(input int x, input int p);
        return ((x % p) + p) % p;
    endfunction

    function automatic void golden(input int p, input int a, input int px, input int py,
                                   input int qx, input int qy, output int rx, output int ry);
        int num, den, inv, s;
        if (px == qx && py == qy) begin
            num = md(3 * px * px + a, p);
            den = md(2 * py, p);
        end else begin
            num = md(qy - py, p);
            den = md(qx - px, p);
        end
        inv = 0;
        for (int i = 1; i < p; i++) if (md(i * den, p) == 1) inv = i;
        s  = md(num * inv, p);
        rx = md(s * s - px - qx, p);
        ry = md(s * (px - rx) - py, p);
    endfunction

    // Three beats, then observe the next eight cycles; the next call's first
    // sample is cycle k+9, where out_valid must already be low.
    task automatic run_job(input logic [W-1:0] px, py, qx, qy, p, a, rx, ry,
                           input bit inject, input string nm);
        logic [9:0]   vpat;
        logic [W-1:0] d7, d8;
        int           bad;
        @(negedge clk);
        check({nm, " idle_before"}, {out_valid, out_data}, 0);
        in_valid = 1'b1; in_x = px; in_y = py;
        @(negedge clk);
        in_x = qx; in_y = qy;
        @(negedge clk);
        in_x = p; in_y = a;
        vpat = '0; bad = 0; d7 = '0; d8 = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin in_valid = 1'b0; in_x = '0; in_y = '0; end
            if (inject && c == 5) begin in_valid = 1'b1; in_x = 6'd3; in_y = 6'd4; end
            if (inject && c == 8) begin in_valid = 1'b0; in_x = '0; in_y = '0; end
            vpat[c] = out_valid;
            if (!out_valid && out_data != '0) bad++;
            if (c == 7) d7 = out_data;
            if (c == 8) d8 = out_data;
        end
        check({nm, " valid_timing"}, 32'(vpat), 32'h180);
        check({nm, " rx"}, 32'(d7), 32'(rx));
        check({nm, " ry"}, 32'(d8), 32'(ry));
        check({nm, " data_zero_when_idle"}, bad, 0);
    endtask

    task automatic reset_job(input int at_c, input string nm);
        int extra;
        @(negedge clk);
        in_valid = 1'b1; in_x = 6'd2; in_y = 6'd7;
        @(negedge clk);
        in_x = 6'd5; in_y = 6'd2;
        @(negedge clk);
        in_x = 6'd11; in_y = 6'd1;
        for (int c = 1; c <= at_c; c++) begin
            @(negedge clk);
            if (c == 1) begin in_valid = 1'b0; in_x = '0; in_y = '0; end
        end
        rst = 1'b1;
        #1;
        check({nm, " valid"}, 32'(out_valid), 0);
        check({nm, " data"}, 32'(out_data), 0);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check({nm, " no_output"}, extra, 0);
    endtask

    vec_t vecs[6];

    initial begin
        int p, a, b, x1, y1, qx, qy, rx, ry, x2, start, quiet;
        bit dbl, found;

        vecs[0] = '{6'd2,  6'd7, 6'd5,  6'd2, 6'd11, 6'd1, 6'd8,  6'd3, "add_2_7__5_2"};
        vecs[1] = '{6'd2,  6'd7, 6'd2,  6'd7, 6'd11, 6'd1, 6'd5,  6'd2, "dbl_2_7"};
        vecs[2] = '{6'd5,  6'd2, 6'd2,  6'd7, 6'd11, 6'd1, 6'd8,  6'd3, "add_5_2__2_7"};
        vecs[3] = '{6'd5,  6'd2, 6'd5,  6'd2, 6'd11, 6'd1, 6'd10, 6'd2, "dbl_5_2"};
        vecs[4] = '{6'd2,  6'd7, 6'd10, 6'd2, 6'd11, 6'd1, 6'd3,  6'd6, "add_2_7__10_2"};
        vecs[5] = '{6'd10, 6'd2, 6'd2,  6'd7, 6'd11, 6'd1, 6'd3,  6'd6, "add_10_2__2_7"};

        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0;
        repeat (2) @(negedge clk);
        check("reset out_valid", 32'(out_valid), 0);
        check("reset out_data", 32'(out_data), 0);
        rst = 1'b0;

        foreach (vecs[i])
            run_job(vecs[i].px, vecs[i].py, vecs[i].qx, vecs[i].qy, vecs[i].p, vecs[i].a,
                    vecs[i].rx, vecs[i].ry, 1'b0, vecs[i].name);

        // A second job offered at k+5 must be dropped without extra output.
        run_job(6'd2, 6'd7, 6'd5, 6'd2, 6'd11, 6'd1, 6'd8, 6'd3, 1'b1, "ignored_job");
        quiet = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) quiet++;
        end
        check("ignored_job no_extra", quiet, 0);

        reset_job(3, "rst_slope");
        run_job(6'd2, 6'd7, 6'd5, 6'd2, 6'd11, 6'd1, 6'd8, 6'd3, 1'b0, "after_rst_slope");
        reset_job(7, "rst_outx");
        run_job(6'd2, 6'd7, 6'd2, 6'd7, 6'd11, 6'd1, 6'd5, 6'd2, 1'b0, "after_rst_outx");

        p = 61;
        for (int j = 0; j < 500; j++) begin
            a  = $urandom_range(0, 60);
            x1 = $urandom_range(0, 60);
            y1 = $urandom_range(1, 60);
            b  = md(y1 * y1 - x1 * x1 * x1 - a * x1, p);
            dbl = ($urandom_range(0, 2) == 0);
            qx = x1; qy = y1; found = 1'b0;
            if (!dbl) begin
                start = $urandom_range(0, 59);
                for (int off = 0; off < 60; off++) begin
                    x2 = (x1 + 1 + ((start + off) % 60)) % 61;
                    for (int y = 0; y < 61; y++) begin
                        if (!found && md(y * y - (x2 * x2 * x2 + a * x2 + b), p) == 0) begin
                            found = 1'b1;
                            qx = x2;
                            qy = $urandom_range(0, 1) ? y : md(-y, p);
                        end
                    end
                end
            end
            golden(p, a, x1, y1, qx, qy, rx, ry);
            run_job(6'(x1), 6'(y1), 6'(qx), 6'(qy), 6'(p), 6'(a), 6'(rx), 6'(ry), 1'b0,
                    found ? "rand_add" : "rand_dbl");
        end

        @(negedge clk);
        check("final idle", {out_valid, out_data}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
